// File: rtl/election_pkg.sv
// Shared sizing and state definitions for the ciphertext stream path.
package election_pkg;

    localparam int REGISTER_SIZE = 32;
    localparam int BITS_IN_NUM   = 4096;

    function automatic int num_blocks(input int reg_size, input int bits);
        return (2 * bits) / reg_size;
    endfunction

    localparam int NUM_BLOCKS = num_blocks(REGISTER_SIZE, BITS_IN_NUM);

    typedef enum logic [1:0] {
        FILL,
        FETCH,
        WAIT,
        SEND
    } buf_state_t;

endpackage

// File: rtl/block_ram_sdp.sv
// Simple dual-port RAM: one write port, one read port, registered read.
module block_ram_sdp #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so the tools can map to BRAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ciphertext_stream_buffer.sv
// Captures one ciphertext as blocks into RAM, then drains it as bytes.
module ciphertext_stream_buffer #(
    parameter int REGISTER_SIZE = election_pkg::REGISTER_SIZE,
    parameter int BITS_IN_NUM   = election_pkg::BITS_IN_NUM,
    localparam int NUM_BLOCKS   = election_pkg::num_blocks(REGISTER_SIZE, BITS_IN_NUM),
    localparam int CNT_W        = $clog2(NUM_BLOCKS + 1)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     valid_in,
    input  logic [REGISTER_SIZE-1:0] block_in,
    output logic                     ready_out,
    output logic [7:0]               byte_out,
    output logic                     byte_valid_out,
    input  logic                     byte_ready_in,
    output logic                     done_out,
    output logic                     overflow_out,
    output logic [CNT_W-1:0]         blocks_stored_out
);

    import election_pkg::*;

    localparam int BYTES_PER_BLOCK = REGISTER_SIZE / 8;
    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int SEL_W = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
    localparam logic [IDX_W-1:0] LAST_BLK  = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [SEL_W-1:0] LAST_BYTE = SEL_W'(BYTES_PER_BLOCK - 1);

    buf_state_t               state, state_d;
    logic [IDX_W-1:0]         wr_idx, wr_idx_d;
    logic [IDX_W-1:0]         rd_idx, rd_idx_d;
    logic [SEL_W-1:0]         byte_sel, byte_sel_d;
    logic [REGISTER_SIZE-1:0] shift_q, shift_d;
    logic                     done_q, done_d;
    logic                     overflow_q, overflow_d;
    logic                     ram_we, ram_re;
    logic [REGISTER_SIZE-1:0] ram_rdata;

    block_ram_sdp #(
        .DEPTH  (NUM_BLOCKS),
        .WIDTH  (REGISTER_SIZE),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk   (clk_in),
        .we    (ram_we),
        .waddr (wr_idx),
        .wdata (block_in),
        .re    (ram_re),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= FILL;
            wr_idx     <= '0;
            rd_idx     <= '0;
            byte_sel   <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_d;
            wr_idx     <= wr_idx_d;
            rd_idx     <= rd_idx_d;
            byte_sel   <= byte_sel_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state;
        wr_idx_d   = wr_idx;
        rd_idx_d   = rd_idx;
        byte_sel_d = byte_sel;
        shift_d    = shift_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        // Blocks arriving outside FILL are lost; remember that it happened.
        overflow_d = overflow_q | (valid_in && (state != FILL));

        unique case (state)
            FILL: begin
                if (valid_in) begin
                    ram_we = 1'b1;
                    if (wr_idx == LAST_BLK) begin
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        state_d  = FETCH;
                    end else begin
                        wr_idx_d = wr_idx + 1'b1;
                    end
                end
            end
            FETCH: begin
                ram_re  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                shift_d    = ram_rdata;
                byte_sel_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (byte_ready_in) begin
                    shift_d = shift_q >> 8;
                    if (byte_sel == LAST_BYTE) begin
                        byte_sel_d = '0;
                        if (rd_idx == LAST_BLK) begin
                            state_d = FILL;
                            done_d  = 1'b1;
                        end else begin
                            rd_idx_d = rd_idx + 1'b1;
                            state_d  = FETCH;
                        end
                    end else begin
                        byte_sel_d = byte_sel + 1'b1;
                    end
                end
            end
        endcase
    end

    assign ready_out      = (state == FILL);
    assign byte_valid_out = (state == SEND);
    assign byte_out       = shift_q[7:0];
    assign done_out       = done_q;
    assign overflow_out   = overflow_q;

    // While draining, the whole ciphertext is held in RAM.
    assign blocks_stored_out = (state == FILL) ? CNT_W'(wr_idx)
                                               : CNT_W'(NUM_BLOCKS);

endmodule

// File: tb/tb_ciphertext_stream_buffer.sv
// Directed and randomized checks of the ciphertext capture/drain buffer.
module tb_ciphertext_stream_buffer;

    localparam int RS   = 32;
    localparam int BITS = 64;
    localparam int NB   = 2 * BITS / RS;
    localparam int BPB  = RS / 8;
    localparam int CW   = $clog2(NB + 1);

    typedef logic [RS-1:0] blk_arr_t [NB];

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          valid_in = 1'b0;
    logic [RS-1:0] block_in = '0;
    logic          byte_ready_in = 1'b0;
    logic          ready_out;
    logic [7:0]    byte_out;
    logic          byte_valid_out;
    logic          done_out;
    logic          overflow_out;
    logic [CW-1:0] blocks_stored_out;

    int checks = 0;
    int passed = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    blk_arr_t t1;
    blk_arr_t rb;

    ciphertext_stream_buffer #(
        .REGISTER_SIZE (RS),
        .BITS_IN_NUM   (BITS)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .valid_in          (valid_in),
        .block_in          (block_in),
        .ready_out         (ready_out),
        .byte_out          (byte_out),
        .byte_valid_out    (byte_valid_out),
        .byte_ready_in     (byte_ready_in),
        .done_out          (done_out),
        .overflow_out      (overflow_out),
        .blocks_stored_out (blocks_stored_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: note what the sink accepts at this edge, sample after it.
    task automatic step();
        logic       acc;
        logic [7:0] b;
        acc = byte_valid_out && byte_ready_in;
        b   = byte_out;
        @(posedge clk_in);
        #1;
        if (acc) got_q.push_back(b);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, ready_out, 1);
        check({tag, "_bvalid"}, byte_valid_out, 0);
        check({tag, "_byte"}, byte_out, 0);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_ovf"}, overflow_out, 0);
        check({tag, "_stored"}, blocks_stored_out, 0);
    endtask

    task automatic async_reset();
        for (int i = 0; i < got_q.size(); i++)
            check($sformatf("pre_reset_byte%0d", i), got_q[i], exp_q[i]);
        #2 rst_in = 1'b1;
        #1 check_reset_vals("async_rst");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        byte_ready_in = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic fill(input blk_arr_t blk, input int gap);
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < BPB; k++)
                exp_q.push_back(8'(blk[i] >> (8 * k)));
            check("stored_pre", blocks_stored_out, i);
            for (int g = 0; g < gap; g++) begin
                valid_in = 1'b0;
                step();
                check("stored_idle", blocks_stored_out, i);
            end
            check("ready_fill", ready_out, 1);
            valid_in = 1'b1;
            block_in = blk[i];
            step();
            valid_in = 1'b0;
            if (i < NB - 1) begin
                check("stored_inc", blocks_stored_out, i + 1);
            end else begin
                check("ready_drop", ready_out, 0);
                check("stored_full", blocks_stored_out, NB);
                check("valid_fetch", byte_valid_out, 0);
            end
        end
    endtask

    task automatic drain(input bit rnd, input bit inject,
                         input int abort_at, input bit tail);
        int         n;
        int         low;
        bit         stall;
        bit         done_seen;
        bit         injected;
        logic [7:0] pb;
        logic [7:0] g;
        n = 0;
        byte_ready_in = 1'b1;
        while (!byte_valid_out && n < 8) begin
            step();
            n++;
        end
        check("first_byte_latency", n + 1, 3);
        low = 0;
        stall = 1'b0;
        done_seen = 1'b0;
        injected = 1'b0;
        pb = '0;
        for (int c = 0; c < 500; c++) begin
            if (stall)
                check("stall_stable", {byte_valid_out, byte_out}, {1'b1, pb});
            if (byte_valid_out) begin
                if (low > 0) check("block_bubble", low, 2);
                low = 0;
            end else begin
                low++;
            end
            byte_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            valid_in = 1'b0;
            if (inject && !injected && got_q.size() == 5) begin
                valid_in = 1'b1;
                block_in = 32'hDEADBEEF;
                injected = 1'b1;
            end
            stall = byte_valid_out && !byte_ready_in;
            pb = byte_out;
            step();
            valid_in = 1'b0;
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                async_reset();
                return;
            end
            if (done_out) begin
                done_seen = 1'b1;
                break;
            end
        end
        check("done_seen", done_seen, 1);
        check("ready_after_done", ready_out, 1);
        check("stored_after_done", blocks_stored_out, 0);
        check("byte_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("byte%0d", i), g, exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
        if (inject) check("overflow_set", overflow_out, 1);
        if (tail) begin
            step();
            check("done_once", done_out, 0);
        end
    endtask

    task automatic rand_blocks();
        for (int i = 0; i < NB; i++) rb[i] = $urandom();
    endtask

    initial begin
        t1 = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_vals("reset");
        rst_in = 1'b0;

        // Plain capture and full-rate drain.
        fill(t1, 0);
        drain(1'b0, 1'b0, -1, 1'b1);

        // Random sink backpressure.
        fill(t1, 0);
        drain(1'b1, 1'b0, -1, 1'b1);
        check("no_overflow", overflow_out, 0);

        // A block arriving mid-drain is dropped and flagged.
        fill(t1, 0);
        drain(1'b0, 1'b1, -1, 1'b1);
        step();
        check("overflow_sticky", overflow_out, 1);

        // Second ciphertext starts in the done cycle.
        fill(t1, 0);
        drain(1'b0, 1'b0, -1, 1'b0);
        rand_blocks();
        fill(rb, 0);
        drain(1'b1, 1'b0, -1, 1'b1);
        check("overflow_held", overflow_out, 1);

        // Asynchronous reset after six bytes, then a fresh ciphertext.
        rand_blocks();
        fill(rb, 0);
        drain(1'b0, 1'b0, 6, 1'b0);
        rand_blocks();
        fill(rb, 0);
        drain(1'b0, 1'b0, -1, 1'b1);

        // Blocks with idle gaps between them.
        fill(t1, 2);
        drain(1'b0, 1'b0, -1, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ciphertext_stream_buffer.md
Name: ciphertext_stream_buffer

Overview:
- Downstream consumer of the candidate encryptor's block stream.
- Captures one complete ciphertext (mod n², 2·BITS_IN_NUM bits) arriving as REGISTER_SIZE-bit blocks, least-significant block first, into on-chip RAM.
- Once the ciphertext is complete, drains it as a byte stream over a valid/ready handshake to the UART transmitter.
- Isolates the encryptor's free-running block output from the slower serial link.

Parameters:
- REGISTER_SIZE, 32, width of one input block; must be a multiple of 8.
- BITS_IN_NUM, 4096, modulus n width; ciphertext is 2·BITS_IN_NUM bits.
- NUM_BLOCKS (localparam), 2·BITS_IN_NUM/REGISTER_SIZE, blocks per ciphertext (256 at defaults).
- BYTES_PER_BLOCK (localparam), REGISTER_SIZE/8.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  block_in holds a valid ciphertext block this cycle.
- block_in  input  REGISTER_SIZE  ciphertext block, LSB block first.
- ready_out  output  1  high while blocks are accepted (FILL state).
- byte_out  output  8  current output byte.
- byte_valid_out  output  1  byte_out valid.
- byte_ready_in  input  1  sink accepts byte_out this cycle.
- done_out  output  1  one-cycle pulse after the final byte is accepted.
- overflow_out  output  1  sticky: a valid_in was dropped while not ready.
- blocks_stored_out  output  $clog2(NUM_BLOCKS+1)  blocks written for the current ciphertext.

Behaviour:
- Reset (asynchronous, any time):
  - State goes to FILL; all counters are 0.
  - ready_out=1; byte_valid_out=0; done_out=0; overflow_out=0; byte_out=0.
  - Any partial ciphertext is discarded; RAM contents are don't-care.
- States: FILL, FETCH, WAIT, SEND.
- FILL:
  - Each cycle with valid_in=1 writes block_in to RAM[wr_idx] and increments wr_idx.
  - blocks_stored_out equals wr_idx.
  - A write with wr_idx==NUM_BLOCKS-1 moves the state to FETCH next cycle, with rd_idx=0 and wr_idx cleared.
- FETCH: issue RAM read at rd_idx; go to WAIT.
- WAIT: RAM data returns (1-cycle read latency); load it into the shift register; byte_sel=0; go to SEND.
- SEND:
  - byte_valid_out=1; byte_out = shift register bits [7:0]. Bytes go out LSB-first within a block.
  - On byte_valid_out && byte_ready_in: shift right by 8 and increment byte_sel.
  - byte_out must stay stable while byte_ready_in=0.
  - Last byte of a block accepted, rd_idx<NUM_BLOCKS-1: rd_idx++, go to FETCH. The 2-cycle bubble between blocks is required and exact.
  - Last byte of the last block accepted: go to FILL and pulse done_out in the next cycle.
- Latency: final block sampled at edge t → first byte_valid_out high in cycle t+3.
- Output order: the byte stream is the ciphertext little-endian (byte 0 = least-significant 8 bits).
- Backpressure: byte_ready_in may be low indefinitely. No timeout.
- Overflow:
  - valid_in=1 in any state other than FILL is dropped and sets overflow_out, which holds until reset.
  - The dropped block does not disturb the drain in progress.
- ready_out is combinational (state==FILL), so the FILL→FETCH transition cycle already shows ready_out=0.
- Boundary cases:
  - valid_in in the same cycle as the final byte acceptance is dropped, because the state is still SEND.
  - The first accepted block is the one sampled in the cycle done_out is high.
- Width: counters sized $clog2(NUM_BLOCKS) and $clog2(BYTES_PER_BLOCK), with explicit compare against the last index; no reliance on wrap-around.

Decomposition:
- Shared package (election_pkg): REGISTER_SIZE, BITS_IN_NUM, the NUM_BLOCKS derivation, and the state enum type buf_state_t.
- Sub-module: block_ram_sdp, a simple dual-port RAM with NUM_BLOCKS×REGISTER_SIZE, one write port, one read port, and 1-cycle registered read. It is inferred as BRAM.

Test Plan (REGISTER_SIZE=32, BITS_IN_NUM=64 → 4 blocks, 16 bytes):
- Blocks 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles with byte_ready_in=1 → bytes 0x00..0x0F in order, first byte 3 cycles after the last block, 2-cycle gap per block, done_out pulses once, ready_out returns to 1.
- Same stimulus with byte_ready_in toggled 1/0 randomly → identical byte sequence, byte_out stable while stalled, no duplicates or losses.
- valid_in=1 with 0xDEADBEEF during SEND → overflow_out=1 and stays high; drained bytes are unchanged 0x00..0x0F.
- Two ciphertexts back-to-back, the second beginning the cycle done_out is high → both stream correctly; blocks_stored_out goes 0→4 for each.
- rst_in asserted asynchronously mid-SEND (after byte 6) → outputs immediately return to reset values; a new 4-block ciphertext then streams correctly from byte 0.
- Blocks with idle gaps (valid_in high every third cycle) → blocks_stored_out increments only on valid cycles; output matches the first test.
